// File: rtl/rename_ckpt_ctrl_if.sv
// Signal bundle between branch resolution / rename and the checkpoint controller.
// The controller attaches through the slave modport; the pipeline side uses master.
interface rename_ckpt_ctrl_if #(
    parameter int CKPT_DEPTH = 4
);
    localparam int TAGW = $clog2(CKPT_DEPTH);

    // br_alloc is a valid with no ready: it is accepted only in a cycle where
    // stall is low and no live mispredict is presented, otherwise it is dropped
    // and the rename stage must present the same branch again.
    logic            br_alloc;
    logic [6:0]      curr_pos;
    logic            list_empty;
    logic            ext_stall;
    logic            br_resolve;
    logic [TAGW-1:0] br_resolve_tag;
    logic            br_mispredict;
    logic [TAGW-1:0] br_tag;
    logic            ckpt_full;
    logic [TAGW:0]   ckpt_count;
    logic            flush;
    logic [6:0]      flush_pos;
    logic            stall;
    logic [1:0]      dbg_state;

    modport master (
        output br_alloc, curr_pos, list_empty, ext_stall,
               br_resolve, br_resolve_tag, br_mispredict,
        input  br_tag, ckpt_full, ckpt_count, flush, flush_pos, stall, dbg_state
    );

    modport slave (
        input  br_alloc, curr_pos, list_empty, ext_stall,
               br_resolve, br_resolve_tag, br_mispredict,
        output br_tag, ckpt_full, ckpt_count, flush, flush_pos, stall, dbg_state
    );
endinterface

// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint ring for the rename free list: saves curr_pos per branch, retires in order,
// and on a mispredict drives flush/flush_pos then stalls rename. CKPT_STATS_EN adds flush_count.
module rename_ckpt_ctrl #(
    parameter int CKPT_DEPTH     = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rename_ckpt_ctrl_if.slave     ckpt_if
`ifdef CKPT_STATS_EN
    ,
    output logic [15:0]           flush_count
`endif
);
    localparam int TAGW = $clog2(CKPT_DEPTH);
    localparam int RCW  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [TAGW:0]   CNT_ONE  = (TAGW+1)'(1);
    localparam logic [TAGW:0]   CNT_FULL = (TAGW+1)'(CKPT_DEPTH);
    localparam logic [TAGW-1:0] PTR_ONE  = TAGW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [RCW-1:0]        rcnt_q, rcnt_d;
    logic [TAGW-1:0]       head_q, head_d;
    logic [TAGW-1:0]       tail_q, tail_d;
    logic [TAGW:0]         count_q, count_d;
    logic [CKPT_DEPTH-1:0] valid_q, valid_d;
    logic [CKPT_DEPTH-1:0] done_q, done_d;
    logic [6:0]            pos_q [CKPT_DEPTH];
    logic [6:0]            pos_d [CKPT_DEPTH];
    logic                  flush_q, flush_d;
    logic [6:0]            flush_pos_q, flush_pos_d;

    logic                  full;
    logic                  stall_w;
    logic [TAGW-1:0]       rtag;
    logic                  tag_live;
    logic                  mp_live;
    logic                  ok_live;
    logic                  alloc_acc;
    logic                  retire;
    logic [TAGW-1:0]       tag_off;

    assign rtag      = ckpt_if.br_resolve_tag;
    assign full      = (count_q == CNT_FULL);
    assign stall_w   = !rst_n | (state_q != IDLE) | full | ckpt_if.list_empty | ckpt_if.ext_stall;
    assign tag_live  = valid_q[rtag];
    assign mp_live   = ckpt_if.br_resolve & ckpt_if.br_mispredict & tag_live;
    assign ok_live   = ckpt_if.br_resolve & !ckpt_if.br_mispredict & tag_live;
    assign alloc_acc = ckpt_if.br_alloc & !stall_w & !mp_live;
    // Retiring head is cancelled when the mispredicted tag is head itself.
    assign retire    = valid_q[head_q] & done_q[head_q] & !(mp_live & (rtag == head_q));
    assign tag_off   = rtag - head_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        done_d      = done_q;
        pos_d       = pos_q;
        flush_pos_d = flush_pos_q;

        if (retire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (ok_live) begin
            done_d[rtag] = 1'b1;
        end
        if (alloc_acc) begin
            pos_d[tail_q]   = ckpt_if.curr_pos;
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + PTR_ONE;
        end
        case ({alloc_acc, retire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Entries are ordered by distance from head, so the squashed set is
        // everything at or beyond the mispredicted tag's distance.
        if (mp_live) begin
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                if (TAGW'(TAGW'(i) - head_q) >= tag_off) begin
                    valid_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
            tail_d      = rtag;
            count_d     = {1'b0, TAGW'(rtag - head_d)};
            flush_pos_d = pos_q[rtag];
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: ;
            FLUSH: begin
                state_d = DRAIN;
                rcnt_d  = RCW'(RECOVER_CYCLES - 1);
            end
            DRAIN: begin
                if (rcnt_q == '0) state_d = IDLE;
                else              rcnt_d  = rcnt_q - RCW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (mp_live) state_d = FLUSH;
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            flush_q     <= 1'b0;
            flush_pos_q <= 7'h00;
            for (int i = 0; i < CKPT_DEPTH; i++) pos_q[i] <= 7'h00;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            flush_q     <= flush_d;
            flush_pos_q <= flush_pos_d;
            pos_q       <= pos_d;
        end
    end

`ifdef CKPT_STATS_EN
    logic [15:0] flush_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                flush_cnt_q <= 16'h0000;
        else if (mp_live && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
    assign flush_count = flush_cnt_q;
`endif

    assign ckpt_if.br_tag     = tail_q;
    assign ckpt_if.ckpt_full  = full;
    assign ckpt_if.ckpt_count = count_q;
    assign ckpt_if.flush      = flush_q;
    assign ckpt_if.flush_pos  = flush_pos_q;
    assign ckpt_if.stall      = stall_w;
    assign ckpt_if.dbg_state  = state_q;
endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Directed bench for rename_ckpt_ctrl: allocation, in-order retire, mispredict recovery,
// nested flush, boundary stalls and asynchronous reset; flush_count when CKPT_STATS_EN is set.
module tb_rename_ckpt_ctrl;
    localparam int D    = 4;
    localparam int RC   = 2;
    localparam int TAGW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [TAGW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rename_ckpt_ctrl_if #(.CKPT_DEPTH(D)) bus ();
`ifdef CKPT_STATS_EN
    logic [15:0] flush_count;
`endif

    rename_ckpt_ctrl #(.CKPT_DEPTH(D), .RECOVER_CYCLES(RC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ckpt_if     (bus.slave)
`ifdef CKPT_STATS_EN
        ,
        .flush_count (flush_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.br_alloc       = 1'b0;
        bus.curr_pos       = 7'h00;
        bus.list_empty     = 1'b0;
        bus.ext_stall      = 1'b0;
        bus.br_resolve     = 1'b0;
        bus.br_resolve_tag = '0;
        bus.br_mispredict  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [6:0] p);
        bus.br_alloc = 1'b1;
        bus.curr_pos = p;
        tick();
        bus.br_alloc = 1'b0;
    endtask

    task automatic resolve(input logic [TAGW-1:0] tag, input logic mp);
        bus.br_resolve     = 1'b1;
        bus.br_resolve_tag = tag;
        bus.br_mispredict  = mp;
        tick();
        bus.br_resolve     = 1'b0;
        bus.br_mispredict  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        tick();
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %0h exp 1", bus.stall); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h exp 0", bus.flush); end
        checks++; if (bus.flush_pos !== 7'h00) begin errors++; $display("FAIL reset_flush_pos: got %0h exp 0", bus.flush_pos); end
        checks++; if (bus.ckpt_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.ckpt_count); end
        checks++; if (bus.ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h exp 0", bus.ckpt_full); end
        checks++; if (bus.br_tag !== 2'd0) begin errors++; $display("FAIL reset_br_tag: got %0d exp 0", bus.br_tag); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", bus.dbg_state); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_release_stall: got %0h exp 0", bus.stall); end
    endtask

    task automatic test_fill();
        logic [6:0]      pv [4];
        logic [TAGW-1:0] et;
        pv = '{7'h10, 7'h12, 7'h15, 7'h7F};
        for (int i = 0; i < 4; i++) exp_q.push_back(TAGW'(i));
        for (int i = 0; i < 4; i++) begin
            bus.br_alloc = 1'b1;
            bus.curr_pos = pv[i];
            #1;
            et = exp_q.pop_front();
            checks++; if (bus.br_tag !== et) begin errors++; $display("FAIL fill_br_tag[%0d]: got %0d exp %0d", i, bus.br_tag, et); end
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall[%0d]: got %0h exp 0", i, bus.stall); end
            tick();
        end
        bus.curr_pos = 7'h55;
        #1;
        checks++; if (bus.ckpt_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0h exp 1", bus.ckpt_full); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fill_stall_full: got %0h exp 1", bus.stall); end
        tick();
        bus.br_alloc = 1'b0;
        #1;
        checks++; if (bus.ckpt_count !== 3'd4) begin errors++; $display("FAIL fill_drop_count: got %0d exp 4", bus.ckpt_count); end
        checks++; if (bus.br_tag !== 2'd0) begin errors++; $display("FAIL fill_drop_tag: got %0d exp 0", bus.br_tag); end
    endtask

    task automatic test_retire();
        resolve(2'd0, 1'b0);
        #1;
        checks++; if (bus.ckpt_count !== 3'd4) begin errors++; $display("FAIL retire_early_count: got %0d exp 4", bus.ckpt_count); end
        tick();
        #1;
        checks++; if (bus.ckpt_count !== 3'd3) begin errors++; $display("FAIL retire_count: got %0d exp 3", bus.ckpt_count); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL retire_stall: got %0h exp 0", bus.stall); end
        resolve(2'd2, 1'b0);
        tick();
        tick();
        #1;
        checks++; if (bus.ckpt_count !== 3'd3) begin errors++; $display("FAIL ooo_hold_count: got %0d exp 3", bus.ckpt_count); end
        resolve(2'd1, 1'b0);
        tick();
        #1;
        checks++; if (bus.ckpt_count !== 3'd2) begin errors++; $display("FAIL ooo_retire1_count: got %0d exp 2", bus.ckpt_count); end
        tick();
        #1;
        checks++; if (bus.ckpt_count !== 3'd1) begin errors++; $display("FAIL ooo_retire2_count: got %0d exp 1", bus.ckpt_count); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(7'h10);
        alloc(7'h12);
        alloc(7'h15);
        bus.br_resolve     = 1'b1;
        bus.br_resolve_tag = 2'd1;
        bus.br_mispredict  = 1'b1;
        bus.br_alloc       = 1'b1;
        bus.curr_pos       = 7'h33;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mp_pre_stall: got %0h exp 0", bus.stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL mp_flush: got %0h exp 1", bus.flush); end
        checks++; if (bus.flush_pos !== 7'h12) begin errors++; $display("FAIL mp_flush_pos: got %0h exp 12", bus.flush_pos); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mp_stall_n1: got %0h exp 1", bus.stall); end
        checks++; if (bus.br_tag !== 2'd1) begin errors++; $display("FAIL mp_tail: got %0d exp 1", bus.br_tag); end
        checks++; if (bus.ckpt_count !== 3'd1) begin errors++; $display("FAIL mp_count: got %0d exp 1", bus.ckpt_count); end
        checks++; if (bus.dbg_state !== 2'd1) begin errors++; $display("FAIL mp_state_flush: got %0d exp 1", bus.dbg_state); end
        tick();
        #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL mp_drain_flush: got %0h exp 0", bus.flush); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mp_stall_n2: got %0h exp 1", bus.stall); end
        checks++; if (bus.flush_pos !== 7'h12) begin errors++; $display("FAIL mp_hold_pos: got %0h exp 12", bus.flush_pos); end
        checks++; if (bus.dbg_state !== 2'd2) begin errors++; $display("FAIL mp_state_drain: got %0d exp 2", bus.dbg_state); end
        tick();
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mp_stall_n3: got %0h exp 1", bus.stall); end
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mp_stall_n4: got %0h exp 0", bus.stall); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL mp_state_idle: got %0d exp 0", bus.dbg_state); end
    endtask

    task automatic test_dead_resolve();
        resolve(2'd2, 1'b1);
        #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL dead_flush: got %0h exp 0", bus.flush); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL dead_stall: got %0h exp 0", bus.stall); end
        checks++; if (bus.ckpt_count !== 3'd1) begin errors++; $display("FAIL dead_count: got %0d exp 1", bus.ckpt_count); end
        alloc(7'h40);
        #1;
        checks++; if (bus.br_tag !== 2'd2) begin errors++; $display("FAIL dead_realloc_tag: got %0d exp 2", bus.br_tag); end
        checks++; if (bus.ckpt_count !== 3'd2) begin errors++; $display("FAIL dead_realloc_count: got %0d exp 2", bus.ckpt_count); end
    endtask

    task automatic test_nested();
        do_reset();
        alloc(7'h20);
        alloc(7'h21);
        alloc(7'h22);
        resolve(2'd2, 1'b1);
        #1;
        checks++; if (bus.flush_pos !== 7'h22) begin errors++; $display("FAIL nest_pos1: got %0h exp 22", bus.flush_pos); end
        checks++; if (bus.ckpt_count !== 3'd2) begin errors++; $display("FAIL nest_count1: got %0d exp 2", bus.ckpt_count); end
        tick();
        #1;
        checks++; if (bus.dbg_state !== 2'd2) begin errors++; $display("FAIL nest_in_drain: got %0d exp 2", bus.dbg_state); end
        resolve(2'd0, 1'b1);
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL nest_flush: got %0h exp 1", bus.flush); end
        checks++; if (bus.flush_pos !== 7'h20) begin errors++; $display("FAIL nest_pos2: got %0h exp 20", bus.flush_pos); end
        checks++; if (bus.ckpt_count !== 3'd0) begin errors++; $display("FAIL nest_count2: got %0d exp 0", bus.ckpt_count); end
        checks++; if (bus.br_tag !== 2'd0) begin errors++; $display("FAIL nest_tail: got %0d exp 0", bus.br_tag); end
        tick();
        tick();
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL nest_drain_stall: got %0h exp 1", bus.stall); end
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL nest_idle_stall: got %0h exp 0", bus.stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.br_alloc = 1'b1;
        bus.curr_pos = 7'h01;
        tick();
        bus.curr_pos       = 7'h02;
        bus.br_resolve     = 1'b1;
        bus.br_resolve_tag = 2'd0;
        tick();
        bus.curr_pos   = 7'h03;
        bus.br_resolve = 1'b0;
        #1;
        checks++; if (bus.ckpt_count !== 3'd2) begin errors++; $display("FAIL b2b_count_pre: got %0d exp 2", bus.ckpt_count); end
        tick();
        bus.br_alloc = 1'b0;
        #1;
        checks++; if (bus.ckpt_count !== 3'd2) begin errors++; $display("FAIL b2b_count_same: got %0d exp 2", bus.ckpt_count); end
        checks++; if (bus.br_tag !== 2'd3) begin errors++; $display("FAIL b2b_tail: got %0d exp 3", bus.br_tag); end
    endtask

    task automatic test_list_empty();
        do_reset();
        bus.list_empty = 1'b1;
        bus.br_alloc   = 1'b1;
        bus.curr_pos   = 7'h40;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL empty_stall: got %0h exp 1", bus.stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.ckpt_count !== 3'd0) begin errors++; $display("FAIL empty_count: got %0d exp 0", bus.ckpt_count); end
        checks++; if (bus.br_tag !== 2'd0) begin errors++; $display("FAIL empty_tag: got %0d exp 0", bus.br_tag); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        alloc(7'h30);
        alloc(7'h31);
        resolve(2'd1, 1'b1);
        tick();
        #1;
        checks++; if (bus.dbg_state !== 2'd2) begin errors++; $display("FAIL rstd_in_drain: got %0d exp 2", bus.dbg_state); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL rstd_state: got %0d exp 0", bus.dbg_state); end
        checks++; if (bus.flush_pos !== 7'h00) begin errors++; $display("FAIL rstd_flush_pos: got %0h exp 0", bus.flush_pos); end
        checks++; if (bus.ckpt_count !== 3'd0) begin errors++; $display("FAIL rstd_count: got %0d exp 0", bus.ckpt_count); end
        checks++; if (bus.br_tag !== 2'd0) begin errors++; $display("FAIL rstd_tag: got %0d exp 0", bus.br_tag); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rstd_flush: got %0h exp 0", bus.flush); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstd_stall: got %0h exp 1", bus.stall); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstd_release: got %0h exp 0", bus.stall); end
    endtask

`ifdef CKPT_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d exp 0", flush_count); end
        alloc(7'h50);
        alloc(7'h51);
        alloc(7'h52);
        resolve(2'd2, 1'b1);
        resolve(2'd1, 1'b1);
        tick();
        resolve(2'd0, 1'b1);
        #1;
        checks++; if (flush_count !== 16'd3) begin errors++; $display("FAIL stats_count: got %0d exp 3", flush_count); end
        checks++; if (bus.flush_pos !== 7'h50) begin errors++; $display("FAIL stats_pos: got %0h exp 50", bus.flush_pos); end
        for (int i = 0; i < 4; i++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_retire();
        test_mispredict();
        test_dead_resolve();
        test_nested();
        test_back_to_back();
        test_list_empty();
        test_reset_drain();
`ifdef CKPT_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_ckpt_ctrl.md
# rename_ckpt_ctrl

Branch-checkpoint and recovery controller for the rename free list. It saves the free-list allocation pointer (`curr_pos`) each time a branch is renamed and retires checkpoints in order as branches resolve correctly. On a mispredict it drives the free list's `flush`/`flush_pos` pair with the saved pointer, then holds the global rename `stall` for a programmable recovery window. It sits between branch resolution and the `freeList` block, and owns that block's `flush`, `flush_pos` and `stall` inputs.

## Interface
Parameters:
- `CKPT_DEPTH`, default 4: number of checkpoints; must be a power of two, ≥2.
- `RECOVER_CYCLES`, default 2: stall cycles in DRAIN after the flush cycle; ≥1.
- `TAGW` is local, equal to `$clog2(CKPT_DEPTH)`.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `br_alloc` input, 1 bit: a branch is being renamed this cycle (at most one per cycle).
- `curr_pos` input, 7 bits: free-list allocation pointer, taken from freeList `curr_pos`.
- `list_empty` input, 1 bit: free list exhausted.
- `ext_stall` input, 1 bit: stall request from the rest of the pipeline.
- `br_resolve` input, 1 bit: a branch resolves this cycle.
- `br_resolve_tag` input, `TAGW` bits: tag of the resolving branch.
- `br_mispredict` input, 1 bit: qualifies `br_resolve`; 1 means mispredicted.
- `br_tag` output, `TAGW` bits: tag assigned to `br_alloc`; equals `tail`.
- `ckpt_full` output, 1 bit: `count == CKPT_DEPTH`.
- `ckpt_count` output, `TAGW+1` bits: number of live checkpoints.
- `flush` output, 1 bit: registered; drives freeList `flush`.
- `flush_pos` output, 7 bits: registered; drives freeList `flush_pos`.
- `stall` output, 1 bit: combinational; drives freeList `stall` and the rename stage.
- `flush_count` output, 16 bits: present only with `CKPT_STATS_EN` defined.

## Operation
- Storage: circular buffer of `CKPT_DEPTH` entries. Each entry holds `pos[6:0]`, `valid` and `done`. Pointers: `head` (oldest) and `tail`, each `TAGW` bits, with natural wrap. `count` is `TAGW+1` bits.
- `stall = !rst_n | (state != IDLE) | ckpt_full | list_empty | ext_stall`.
- Allocation is accepted when `br_alloc & !stall & !(br_resolve & br_mispredict & tag_live)`:
  - `pos[tail] <= curr_pos`, `valid <= 1`, `done <= 0`.
  - `tail++`, `count++`.
  - A `br_alloc` that is not accepted is dropped; upstream re-presents it.
- `tag_live` means `valid[br_resolve_tag]`. A resolve with a dead tag is ignored, in every state.
- Correct resolve (`br_resolve & !br_mispredict & tag_live`): `done[tag] <= 1`.
- Retire: if `valid[head] & done[head]` (registered values), clear the entry, `head++`, `count--`. At most one retire per cycle. A retire may occur in the same cycle as an allocation; `count` then stays unchanged.
- Mispredict (`br_resolve & br_mispredict & tag_live`), accepted in any state:
  - `flush_pos <= pos[tag]`.
  - Invalidate `tag` and every younger entry up to `tail-1`.
  - `tail <= tag`, and `count` is recomputed as `tag - head` (mod `CKPT_DEPTH`; when `tag == head` the result is 0).
  - Any retire of `head` in the same cycle is suppressed if `head` lies in the squashed range.
  - `state <= FLUSH`.
- FSM:
  - IDLE: normal operation.
  - FLUSH: lasts exactly 1 cycle, with `flush=1` and `stall=1`. Next state is DRAIN with `rcnt <= RECOVER_CYCLES-1`.
  - DRAIN: `stall=1` and `flush=0`. `rcnt` decrements each cycle; at `rcnt==0` the next state is IDLE.
  - A live mispredict in FLUSH or DRAIN restarts FLUSH with the new `flush_pos`. Only older branches can still be live, so nesting is always toward the oldest branch.
- `flush` is 1 only in FLUSH. `flush_pos` holds its last value otherwise.

## Timing
- Reset values:
  - `head`, `tail`, `count`: 0. All `valid` and `done` bits: 0. State: IDLE.
  - `flush`: 0; `flush_pos`: 7'h00; `ckpt_count`: 0; `ckpt_full`: 0; `br_tag`: 0.
  - `stall`: 1 while `rst_n` is low.
- Reset asserted mid-recovery aborts the recovery immediately, without completing it.
- Mispredict presented in cycle N:
  - `flush=1` and `flush_pos` are valid in cycle N+1.
  - `stall` is high in cycles N+1 through N+1+`RECOVER_CYCLES`.
  - IDLE is reached at N+2+`RECOVER_CYCLES`.
- The captured `pos` is the `curr_pos` of the accept cycle, i.e. the freeList pointer before that cycle's allocation.
- A checkpoint allocated in cycle N can be retired no earlier than N+2, given a resolve in cycle N+1.
- Full boundary: with `count == CKPT_DEPTH`, `stall=1` and no allocation occurs. A retire in that cycle frees a slot for the next cycle.

## Configuration
- `CKPT_STATS_EN` defined:
  - Adds the `flush_count` output.
  - It is a 16-bit saturating counter, incremented on every accepted mispredict, including restarts.
  - Reset value is 0; it holds at 16'hFFFF once saturated.
- Not defined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset, then 4× `br_alloc` with `curr_pos` = 7'h10, 7'h12, 7'h15, 7'h7F -> `br_tag` = 0,1,2,3; after the fourth, `ckpt_full=1` and `stall=1`; a fifth `br_alloc` is dropped.
- Resolve tag 0 correct -> 2 cycles later `ckpt_count=3` and `stall=0`. Resolve tag 2 correct before tag 1 -> no retire until tag 1 resolves, then two consecutive retires.
- Mispredict tag 1 with `pos[1]`=7'h12 in cycle N -> cycle N+1 `flush=1`, `flush_pos=7'h12`; `stall` high for 1+`RECOVER_CYCLES` cycles; `tail=1`; `ckpt_count=1`.
- Mispredict tag 2 in IDLE, then mispredict live tag 0 during DRAIN -> FLUSH restarts with `flush_pos = pos[0]`; `ckpt_count=0` afterwards.
- Resolve of a dead tag, and `br_alloc` in the same cycle as a live mispredict -> dead resolve has no effect; alloc dropped; `tail` equals the mispredicted tag.
- `list_empty=1` in IDLE -> `stall=1` and no allocation. Reset asserted during DRAIN -> all outputs return to their reset values asynchronously. With `CKPT_STATS_EN`, 3 mispredicts -> `flush_count=3`.
